// File: rtl/mac_se_video_shifter.sv
// Mac SE video shifter: fetches 1-bpp framebuffer words, serialises them MSB-first and
// realigns hsync/vsync/active to the serial pixel stream; includes bring-up test patterns.
module mac_se_video_shifter #(
  parameter int H_ACTIVE     = 512,
  parameter int V_ACTIVE     = 342,
  parameter int ADDR_W       = 14,
  parameter int RD_LAT       = 1,
  parameter int VIDEO_INVERT = 0
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              active_in,
  input  logic [9:0]        x_coord,
  input  logic [9:0]        y_coord,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic [1:0]        test_pattern,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [15:0]       fb_rd_data,
  output logic              video,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              active_out,
  output logic              frame_start
);

  localparam int   L       = RD_LAT + 2;
  localparam logic INV_BIT = (VIDEO_INVERT != 0);

  // Frame-boundary registers
  logic              r_vs_prev;
  logic              r_frame_start;
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_mode;

  // Fetch stage
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [RD_LAT-1:0] r_ld;

  // Delay lines, all L deep so every output lines up with the pixel it belongs to
  logic [L-1:0] r_hs_d;
  logic [L-1:0] r_vs_d;
  logic [L-1:0] r_act_d;
  logic [L-1:0] r_x0_d;
  logic [L-1:0] r_x3_d;
  logic [L-1:0] r_y0_d;

  // Shifter
  logic [15:0] r_shreg;
  logic [3:0]  r_cnt;
  logic        r_wv;

  logic              w_vs_rise;
  logic              w_in_range;
  logic              w_visible;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;
  logic [ADDR_W-1:0] w_addr;
  logic              w_load;
  logic              w_act_next;
  logic              w_test;
  logic              w_act_out;
  logic              w_pix;

  assign w_vs_rise  = vsync_in & ~r_vs_prev;
  assign w_in_range = ({1'b0, x_coord} < 11'(H_ACTIVE)) && ({1'b0, y_coord} < 11'(V_ACTIVE));
  assign w_visible  = active_in & w_in_range;
  assign w_fetch    = w_visible && (x_coord[3:0] == 4'd0) && (r_mode == 2'b00);
  assign w_row      = ADDR_W'({y_coord, 5'b0});
  assign w_col      = ADDR_W'(x_coord[9:4]);
  assign w_addr     = r_base + w_row + w_col;
  assign w_load     = r_ld[RD_LAT-1];
  assign w_act_next = r_act_d[L-2];
  assign w_test     = (r_mode != 2'b00);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      // Treat vsync as already high so a high vsync_in at release is not a boundary
      r_vs_prev     <= 1'b1;
      r_frame_start <= 1'b0;
      r_base        <= '0;
      r_mode        <= 2'b00;
    end else begin
      r_vs_prev     <= vsync_in;
      r_frame_start <= w_vs_rise;
      if (w_vs_rise) begin
        r_base <= fb_base;
        r_mode <= test_pattern;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_ld      <= '0;
      r_hs_d    <= '0;
      r_vs_d    <= '0;
      r_act_d   <= '0;
      r_x0_d    <= '0;
      r_x3_d    <= '0;
      r_y0_d    <= '0;
    end else begin
      r_rd_en   <= w_fetch;
      r_rd_addr <= w_fetch ? w_addr : r_rd_addr;
      r_ld      <= RD_LAT'({r_ld, r_rd_en});
      r_hs_d    <= {r_hs_d[L-2:0], hsync_in};
      r_vs_d    <= {r_vs_d[L-2:0], vsync_in};
      r_act_d   <= {r_act_d[L-2:0], w_visible};
      r_x0_d    <= {r_x0_d[L-2:0], x_coord[0]};
      r_x3_d    <= {r_x3_d[L-2:0], x_coord[3]};
      r_y0_d    <= {r_y0_d[L-2:0], y_coord[0]};
    end
  end

  // A word lives for 16 pixels; a back-to-back load lands on the edge its count hits zero
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_wv    <= 1'b0;
    end else if (w_load) begin
      r_shreg <= fb_rd_data;
      r_cnt   <= 4'd15;
      r_wv    <= 1'b1;
    end else begin
      r_shreg <= {r_shreg[14:0], 1'b0};
      if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if ((r_cnt == 4'd0) || !w_act_next) begin
        r_wv <= 1'b0;
      end
    end
  end

  always_comb begin
    w_pix = 1'b0;
    case (r_mode)
      2'b00:   w_pix = r_shreg[15] ^ ~INV_BIT;
      2'b01:   w_pix = r_x0_d[L-1] ^ r_y0_d[L-1];
      2'b10:   w_pix = 1'b1;
      default: w_pix = r_x3_d[L-1];
    endcase
  end

  assign w_act_out   = r_act_d[L-1] & (r_wv | w_test);
  assign active_out  = w_act_out;
  assign video       = w_act_out & w_pix;
  assign hsync_out   = r_hs_d[L-1];
  assign vsync_out   = r_vs_d[L-1];
  assign fb_rd_en    = r_rd_en;
  assign fb_rd_addr  = r_rd_addr;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_mac_se_video_shifter.sv
// Directed bench for mac_se_video_shifter: two instances (RD_LAT=1 and RD_LAT=2) share one
// hand-driven timing stream; outputs are logged per cycle and compared against hand-computed words.
module tb_mac_se_video_shifter;

  localparam int LOGN = 2048;
  localparam int S_V1 = 0, S_A1 = 1, S_HS1 = 2, S_VS1 = 3, S_FS1 = 4;
  localparam int S_V2 = 5, S_A2 = 6, S_HS2 = 7, S_VS2 = 8, S_EN1 = 9, S_EN2 = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs, vs, act;
  logic [9:0]  xc, yc;
  logic [13:0] base;
  logic [1:0]  tp;

  logic        en1, en2;
  logic [13:0] ad1, ad2;
  logic [15:0] rd1, rd2, p2;
  logic        v1, v2, hso1, hso2, vso1, vso2, ao1, ao2, fs1, fs2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rc1 = 0;
  int rc2 = 0;
  int th = 0;

  logic [10:0] lg [0:LOGN-1];
  logic [13:0] ad1_l [0:LOGN-1];
  logic [13:0] ad2_l [0:LOGN-1];

  always #5 clk = ~clk;

  mac_se_video_shifter #(.RD_LAT(1)) dut (
    .clk_in(clk), .reset(rst), .hsync_in(hs), .vsync_in(vs), .active_in(act),
    .x_coord(xc), .y_coord(yc), .fb_base(base), .test_pattern(tp),
    .fb_rd_en(en1), .fb_rd_addr(ad1), .fb_rd_data(rd1),
    .video(v1), .hsync_out(hso1), .vsync_out(vso1), .active_out(ao1), .frame_start(fs1)
  );

  mac_se_video_shifter #(.RD_LAT(2)) dut2 (
    .clk_in(clk), .reset(rst), .hsync_in(hs), .vsync_in(vs), .active_in(act),
    .x_coord(xc), .y_coord(yc), .fb_base(base), .test_pattern(tp),
    .fb_rd_en(en2), .fb_rd_addr(ad2), .fb_rd_data(rd2),
    .video(v2), .hsync_out(hso2), .vsync_out(vso2), .active_out(ao2), .frame_start(fs2)
  );

  function automatic logic [15:0] memval(input logic [13:0] a);
    if (a == 14'd0) return 16'hA5F0;
    return {a[7:0], ~a[7:0]} ^ 16'h1357;
  endfunction

  // Synchronous RAM models: latency 1 and latency 2
  always @(posedge clk) begin
    if (en1) rd1 <= memval(ad1);
    if (en2) p2 <= memval(ad2);
    rd2 <= p2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < LOGN) begin
      lg[cyc] = {en2, en1, vso2, hso2, ao2, v2, fs1, vso1, hso1, ao1, v1};
      ad1_l[cyc] = ad1;
      ad2_l[cyc] = ad2;
    end
    rc1 += int'(en1);
    rc2 += int'(en2);
  endtask

  function automatic logic [31:0] pack(input int sel, input int s, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], lg[s + i][sel]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic a, input int x, input int y, input logic h);
    act = a;
    xc  = 10'(x);
    yc  = 10'(y);
    hs  = h;
  endtask

  task automatic blank(input int n);
    for (int k = 0; k < n; k++) begin
      set_in(1'b0, 600 + k, int'(yc), k == 2);
      if (k == 2) th = cyc;
      tick();
    end
  endtask

  task automatic line(input int y, input int xs, input int xe, output int t0);
    t0 = cyc;
    for (int x = xs; x < xe; x++) begin
      set_in(1'b1, x, y, 1'b0);
      tick();
    end
    blank(8);
  endtask

  task automatic vframe(output int tv);
    tv = cyc;
    vs = 1'b1;
    blank(6);
    vs = 1'b0;
    blank(6);
  endtask

  initial begin
    int t0, tv, tr, t496, c1, c2;
    logic [15:0] w;

    rst = 1'b1; hs = 1'b0; vs = 1'b0; act = 1'b0; xc = '0; yc = '0; base = '0; tp = 2'b00;

    // Reset held with a live stream, vsync high at release
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, i, 0, i[2]);
      vs = (i >= 10);
      tick();
      check("reset_outputs", {21'd0, lg[cyc]}, 32'd0);
    end
    rst = 1'b0;
    tr = cyc;
    blank(4);
    check("no_boundary_at_release", pack(S_FS1, tr + 1, 4), 32'd0);
    vs = 1'b0;
    blank(4);

    // Line 0: word A5F0 at address 0
    line(0, 0, 32, t0);
    check("l0_rd_en1", pack(S_EN1, t0 + 1, 17), 32'h10001);
    check("l0_addr1", 32'(ad1_l[t0 + 1]), 32'd0);
    check("l0_word0_video1", pack(S_V1, t0 + 3, 16), 32'h5A0F);
    check("l0_active1", pack(S_A1, t0 + 2, 18), 32'h1FFFF);
    w = ~memval(14'd1);
    check("l0_word1_video1", pack(S_V1, t0 + 19, 16), 32'(w));
    check("l0_active1_fall", pack(S_A1, t0 + 34, 2), 32'h2);
    check("l0_addr2", 32'(ad2_l[t0 + 1]), 32'd0);
    check("l0_word0_video2", pack(S_V2, t0 + 4, 16), 32'h5A0F);
    check("l0_active2_delay", pack(S_A2, t0 + 3, 2), 32'h1);
    check("hsync1_delay3", pack(S_HS1, th + 2, 3), 32'h2);
    check("hsync2_delay4", pack(S_HS2, th + 3, 3), 32'h2);

    // Last line, full width: 32 reads, last address 10943
    c1 = rc1; c2 = rc2;
    line(341, 0, 496, t0);
    t496 = cyc;
    line(341, 496, 512, t0);
    check("l341_en1", 32'(lg[t496 + 1][S_EN1]), 32'd1);
    check("l341_addr1", 32'(ad1_l[t496 + 1]), 32'd10943);
    check("l341_reads1", 32'(rc1 - c1), 32'd32);
    check("l341_reads2", 32'(rc2 - c2), 32'd32);

    // Out-of-range line with active high is blank
    c1 = rc1;
    line(342, 0, 32, t0);
    check("oor_reads", 32'(rc1 - c1), 32'd0);
    check("oor_video", pack(S_V1, t0 + 3, 16), 32'd0);
    check("oor_active", pack(S_A1, t0 + 3, 16), 32'd0);

    // Base changed mid-frame has no effect until the boundary
    base = 14'd1000;
    line(1, 0, 16, t0);
    check("midframe_base_addr", 32'(ad1_l[t0 + 1]), 32'd32);
    vframe(tv);
    check("frame_start_pulse", pack(S_FS1, tv, 4), 32'h4);
    check("vsync1_delay3", pack(S_VS1, tv + 2, 2), 32'h1);
    check("vsync2_delay4", pack(S_VS2, tv + 3, 2), 32'h1);
    line(0, 0, 16, t0);
    check("new_base_addr1", 32'(ad1_l[t0 + 1]), 32'd1000);
    check("new_base_en2", pack(S_EN2, t0 + 1, 1), 32'd1);
    check("new_base_addr2", 32'(ad2_l[t0 + 1]), 32'd1000);

    // Address wrap modulo 2^14
    base = 14'h3FFF - 14'd10;
    vframe(tv);
    line(0, 496, 512, t0);
    check("wrap_addr", 32'(ad1_l[t0 + 1]), 32'd20);

    // Checkerboard test pattern; later test_pattern changes are ignored
    base = 14'd0;
    tp = 2'b01;
    vframe(tv);
    tp = 2'b10;
    c1 = rc1; c2 = rc2;
    line(2, 0, 16, t0);
    check("chk_y2_video1", pack(S_V1, t0 + 3, 16), 32'h5555);
    check("chk_y2_active1", pack(S_A1, t0 + 3, 16), 32'hFFFF);
    check("chk_y2_video2", pack(S_V2, t0 + 4, 16), 32'h5555);
    line(3, 0, 16, t0);
    check("chk_y3_video1", pack(S_V1, t0 + 3, 16), 32'hAAAA);
    check("chk_no_reads1", 32'(rc1 - c1), 32'd0);
    check("chk_no_reads2", 32'(rc2 - c2), 32'd0);

    // Reset mid-line, released at x=5: blank until the x=16 word
    t0 = cyc;
    for (int x = 0; x < 32; x++) begin
      rst = (x == 3) || (x == 4);
      set_in(1'b1, x, 4, 1'b0);
      tick();
    end
    rst = 1'b0;
    blank(8);
    check("rst_mid_video_blank", pack(S_V1, t0 + 4, 15), 32'd0);
    check("rst_mid_active_blank", pack(S_A1, t0 + 4, 15), 32'd0);
    check("rst_mid_en1", pack(S_EN1, t0 + 17, 1), 32'd1);
    check("rst_mid_addr1", 32'(ad1_l[t0 + 17]), 32'd129);
    w = ~memval(14'd129);
    check("rst_mid_word_video1", pack(S_V1, t0 + 19, 16), 32'(w));
    check("rst_mid_word_active1", pack(S_A1, t0 + 19, 16), 32'hFFFF);
    check("rst_mid_word_video2", pack(S_V2, t0 + 20, 16), 32'(w));

    // Vertical bars pattern: video = x[3]
    tp = 2'b11;
    vframe(tv);
    line(0, 0, 16, t0);
    check("bars_video1", pack(S_V1, t0 + 3, 16), 32'h00FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
